uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 26 ++
 rtl/uart_tx_serializer_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_serializer.sv | 133 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: state encoding, width limits and parity helper.
package uart_tx_pkg;

  localparam int unsigned UART_MAX_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // XOR of the low `width` bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [UART_MAX_DATA_WIDTH-1:0] data,
                                       input int unsigned                    width,
                                       input logic                           odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < UART_MAX_DATA_WIDTH; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel-in handshake plus serial-out status bundle for the UART transmitter.
interface uart_tx_serializer_if;
  import uart_tx_pkg::*;

  logic [UART_MAX_DATA_WIDTH-1:0] tx_data;
  logic                           tx_valid;
  logic                           tx_ready;
  logic                           tx;
  logic                           tx_busy;
  logic                           tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic clear_i,
  output logic bit_end_c,
  output logic bit_pre_end_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  assign bit_end_c     = run_q && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_pre_end_c = run_q && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

  // Free-run within a bit, reload on each bit boundary, stop when cleared.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      cnt_q <= bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_serializer_if.slave tx_if
);

  localparam int unsigned IDX_W = $clog2(UART_MAX_DATA_WIDTH);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  parity_q;
  logic                  tx_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;

  logic accept_c;
  logic stop_last_c;
  logic frame_end_c;
  logic bit_end_c;
  logic bit_pre_end_c;

  assign accept_c    = (state_q == IDLE) && tx_if.tx_valid && ready_q && !rst;
  assign stop_last_c = (idx_q == IDX_W'(STOP_BITS - 1));
  assign frame_end_c = (state_q == STOP) && stop_last_c && bit_end_c;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk           (clk),
    .rst           (rst),
    .start_i       (accept_c),
    .clear_i       (frame_end_c),
    .bit_end_c     (bit_end_c),
    .bit_pre_end_c (bit_pre_end_c)
  );

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_if.tx_valid && ready_q) begin
            shift_q  <= tx_if.tx_data[DATA_WIDTH-1:0];
            parity_q <= (PARITY_EN != 0) ?
                        calc_parity(tx_if.tx_data, DATA_WIDTH, PARITY_ODD != 0) : 1'b0;
            idx_q    <= '0;
            state_q  <= START;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (bit_end_c) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end_c) begin
            shift_q <= shift_q >> 1;
            if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
              idx_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              tx_q  <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          // Raise done one edge early so it lands on the final stop cycle.
          if (stop_last_c && bit_pre_end_c) done_q <= 1'b1;
          if (bit_end_c) begin
            if (stop_last_c) begin
              state_q <= IDLE;
              idx_q   <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.tx       = tx_q;
  assign tx_if.tx_ready = ready_q;
  assign tx_if.tx_busy  = busy_q;
  assign tx_if.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer across four parameterisations (CLKS_PER_BIT=4).
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       vld    [4];
  logic       tx_a   [4];
  logic       rdy_a  [4];
  logic       busy_a [4];
  logic       done_a [4];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  uart_tx_serializer_if if0 ();
  uart_tx_serializer_if if1 ();
  uart_tx_serializer_if if2 ();
  uart_tx_serializer_if if3 ();

  // 8N1
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .tx_if(if0));
  // 8E1
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .tx_if(if1));
  // 8O1
  uart_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u2 (.clk(clk), .rst(rst), .tx_if(if2));
  // 5N2
  uart_tx_serializer #(.DATA_WIDTH(5), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u3 (.clk(clk), .rst(rst), .tx_if(if3));

  assign if0.tx_data = din;   assign if0.tx_valid = vld[0];
  assign if1.tx_data = din;   assign if1.tx_valid = vld[1];
  assign if2.tx_data = din;   assign if2.tx_valid = vld[2];
  assign if3.tx_data = din;   assign if3.tx_valid = vld[3];

  assign tx_a[0] = if0.tx;  assign rdy_a[0] = if0.tx_ready;  assign busy_a[0] = if0.tx_busy;  assign done_a[0] = if0.tx_done;
  assign tx_a[1] = if1.tx;  assign rdy_a[1] = if1.tx_ready;  assign busy_a[1] = if1.tx_busy;  assign done_a[1] = if1.tx_done;
  assign tx_a[2] = if2.tx;  assign rdy_a[2] = if2.tx_ready;  assign busy_a[2] = if2.tx_busy;  assign done_a[2] = if2.tx_done;
  assign tx_a[3] = if3.tx;  assign rdy_a[3] = if3.tx_ready;  assign busy_a[3] = if3.tx_busy;  assign done_a[3] = if3.tx_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one word and check every bit period, status flags, done timing and the idle cycle after.
  task automatic run_frame(input int d, input logic [7:0] data, input int dw, input int par_en,
                           input logic par_bit, input int stops, input int exp_len,
                           input bit hold, input logic [7:0] next_data, input int poke_at,
                           input string tag);
    logic [15:0] f;
    logic [3:0]  s;
    int          nb;
    int          cyc;
    int          done_cnt;
    int          done_at;
    logic        busy_all;
    logic        rdy_any;
    f  = '0;
    nb = 1;
    for (int i = 0; i < dw; i++) begin f[nb] = data[i]; nb++; end
    if (par_en != 0) begin f[nb] = par_bit; nb++; end
    for (int i = 0; i < stops; i++) begin f[nb] = 1'b1; nb++; end
    din    = data;
    vld[d] = 1'b1;
    @(posedge clk); #1;
    din = hold ? next_data : ~data;
    if (!hold) vld[d] = 1'b0;
    cyc = 1; done_cnt = 0; done_at = 0; busy_all = 1'b1; rdy_any = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        s[c]     = tx_a[d];
        busy_all = busy_all & busy_a[d];
        rdy_any  = rdy_any | rdy_a[d];
        if (done_a[d]) begin done_cnt++; done_at = cyc; end
        if (poke_at > 0 && cyc == poke_at) begin
          din = 8'h11; vld[d] = 1'b1;
        end else if (poke_at > 0 && cyc == poke_at + 1) begin
          din = ~data; vld[d] = 1'b0;
        end
        cyc++;
        @(posedge clk); #1;
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(s), {28'd0, {4{f[b]}}});
    end
    check({tag, "_busy_frame"}, 32'(busy_all), 32'd1);
    check({tag, "_ready_frame"}, 32'(rdy_any), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_len));
    check({tag, "_idle_tx"}, 32'(tx_a[d]), 32'd1);
    check({tag, "_idle_ready"}, 32'(rdy_a[d]), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy_a[d]), 32'd0);
    check({tag, "_idle_done"}, 32'(done_a[d]), 32'd0);
  endtask

  initial begin
    logic seen_done;
    logic seen_low;
    rst = 1'b1;
    din = 8'h00;
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx_a[0]), 32'd1);
    check("rst_ready", 32'(rdy_a[0]), 32'd1);
    check("rst_busy", 32'(busy_a[0]), 32'd0);
    check("rst_done", 32'(done_a[0]), 32'd0);
    check("rst_tx_u3", 32'(tx_a[3]), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 8N1 frame: 0,1,0,1,0,0,1,0,1,1
    run_frame(0, 8'hA5, 8, 0, 1'b0, 1, 40, 1'b0, 8'h00, 0, "basic_a5");

    // Parity frames, 44 cycles each
    run_frame(1, 8'hA5, 8, 1, 1'b0, 1, 44, 1'b0, 8'h00, 0, "even_a5");
    run_frame(2, 8'h07, 8, 1, 1'b0, 1, 44, 1'b0, 8'h00, 0, "odd_07");
    run_frame(1, 8'h07, 8, 1, 1'b1, 1, 44, 1'b0, 8'h00, 0, "even_07");
    run_frame(2, 8'hA5, 8, 1, 1'b1, 1, 44, 1'b0, 8'h00, 0, "odd_a5");

    // Width 5, two stop bits, 32 cycles; upper payload bits ignored
    run_frame(3, 8'hFF, 5, 0, 1'b0, 2, 32, 1'b0, 8'h00, 0, "w5_ff");
    run_frame(3, 8'h2A, 5, 0, 1'b0, 2, 32, 1'b0, 8'h00, 0, "w5_2a");

    // Back-to-back with valid held: second start bit two cycles after first done
    run_frame(0, 8'h3C, 8, 0, 1'b0, 1, 40, 1'b1, 8'hC3, 0, "b2b_3c");
    run_frame(0, 8'hC3, 8, 0, 1'b0, 1, 40, 1'b0, 8'h00, 0, "b2b_c3");

    // Valid pulsed mid-frame is ignored
    run_frame(0, 8'hA5, 8, 0, 1'b0, 1, 40, 1'b0, 8'h00, 10, "busy_rej");
    @(posedge clk); #1;
    check("busy_rej_no_restart", 32'(tx_a[0]), 32'd1);

    // Reset during data bit 3 of 0xF0 (bit 3 is 0)
    din = 8'hF0; vld[0] = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    check("midrst_pre_tx", 32'(tx_a[0]), 32'd0);
    check("midrst_pre_busy", 32'(busy_a[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_tx", 32'(tx_a[0]), 32'd1);
    check("midrst_ready", 32'(rdy_a[0]), 32'd1);
    check("midrst_busy", 32'(busy_a[0]), 32'd0);
    check("midrst_done", 32'(done_a[0]), 32'd0);
    seen_done = 1'b0; seen_low = 1'b0;
    repeat (45) begin
      seen_done = seen_done | done_a[0];
      seen_low  = seen_low | ~tx_a[0];
      @(posedge clk); #1;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    check("midrst_line_idle", 32'(seen_low), 32'd0);
    run_frame(0, 8'h55, 8, 0, 1'b0, 1, 40, 1'b0, 8'h00, 0, "after_rst_55");

    // Reset and valid together: no frame starts
    din = 8'h96; vld[0] = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    vld[0] = 1'b0; rst = 1'b0;
    check("coll_ready", 32'(rdy_a[0]), 32'd1);
    seen_low = 1'b0; seen_done = 1'b0;
    repeat (8) begin
      seen_low  = seen_low | ~tx_a[0] | busy_a[0];
      seen_done = seen_done | done_a[0];
      @(posedge clk); #1;
    end
    check("coll_no_frame", 32'(seen_low), 32'd0);
    check("coll_no_done", 32'(seen_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
